bmult_pipe: RTL and testbench
=============================

# bmult_pipe

Parametrised, pipelined radix-4 Booth multiplier with per-transaction signed/unsigned mode and valid/ready flow control on both sides. It is the successor to the fixed one-stage 32x32 multiplier: width and pipeline depth are generics, and backpressure is supported. It sits between operand producers and accumulators in the arithmetic datapath and is verified against the shared A/B/P hex testvector files.

## Interface
- W, default 32: operand width; even, 4..64.
- STAGES, default 3: register stages from accepted input to registered output; 1..4. Latency equals STAGES.
- clk  in  1: sole clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- in_valid  in  1: A, B, is_signed valid this cycle.
- in_ready  out  1: block accepts input this cycle.
- A  in  W: multiplicand.
- B  in  W: multiplier.
- is_signed  in  1: 1 = both operands two's complement; 0 = both unsigned.
- P  out  2W: product, full width, no truncation.
- out_valid  out  1: P valid.
- out_ready  in  1: consumer accepts P this cycle.

## Operation
- Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Stage 1 registers Booth-recoded partial products: B is extended by one bit (sign bit if is_signed, else 0) to W+2 bits. This yields W/2+1 digits in {-2,-1,0,+1,+2}, each selecting 0, ±A, or ±2A. A is sign- or zero-extended per is_signed.
- Middle stages reduce the partial products with carry-save compression. The final stage performs the carry-propagate add into P.
- The split of reduction levels across stages is free, provided the total latency is exactly STAGES.
- STAGES=1 collapses all work into one stage. Its result timing then matches the legacy one-stage multiplier, plus the handshake.
- is_signed travels with its data through every stage. Mixed modes on back-to-back transactions must each be correct.
- Every stage holds a valid bit; stage data advances only with the global enable.
- Global enable: en = !(out_valid && !out_ready). in_ready = en && !rst.
- No bubble collapsing: while stalled, the entire pipeline freezes, including empty stages.
- Arithmetic, unsigned: P = A*B, max (2^W-1)^2.
- Arithmetic, signed: P = $signed(A)*$signed(B) in 2W bits. -2^(W-1) * -2^(W-1) = 2^(2W-2) is representable and must be exact.

## Timing
- Reset: all stage valid bits cleared; out_valid=0; P=0; in_ready=0 while rst is high, and 1 in the first cycle after release. Data registers other than P need not be reset.
- Reset mid-operation: all in-flight transactions are discarded and no out_valid follows. It takes priority over any simultaneous input or output transfer.
- Latency: a transfer accepted at edge k with no stalls gives out_valid=1 and the correct P after edge k+STAGES-1. P is visible in the cycle following that edge.
- Throughput: one result per cycle while out_ready=1.
- Stall: P and out_valid are held stable while out_valid && !out_ready. in_ready is deasserted combinationally in the same cycle.
- Simultaneous output transfer and new input while full: both occur; there is no loss and no duplication.
- out_valid must not depend combinationally on in_valid.
- in_ready depends combinationally on out_ready only.

## Structure
- Package bmult_pkg holds:
  - enum booth_digit_t {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2};
  - function booth_encode(3-bit window) -> booth_digit_t;
  - localparam function n_pp(W) = W/2+1.
- Sub-module bmult_booth_pp: one digit plus extended A in, one sign-extended partial product row and its negate-carry bit out. Instantiate it once per digit with generate.
- Top level holds the stage registers, valid chain, enable logic, compressor levels and final adder.

## Test plan
- Reset, then W=32, STAGES=3, unsigned A=0xFFFFFFFF, B=0xFFFFFFFF, out_ready=1 -> P=0xFFFFFFFE00000001 with out_valid exactly 3 cycles after acceptance.
- Signed A=0x80000000, B=0x80000000 -> P=0x4000000000000000. Signed A=0xFFFFFFFF (-1), B=0x00000005 -> P=0xFFFFFFFFFFFFFFFB.
- Alternate is_signed every cycle with A=B=0xFFFFFFFF -> results alternate 0xFFFFFFFE00000001 and 0x0000000000000001, in order.
- Stream 8 transactions, drop out_ready for 4 cycles mid-stream:
  - P held stable and in_ready=0 during the drop;
  - all 8 results arrive in order with no duplicates.
- Assert rst while 3 transactions are in flight -> out_valid=0 and P=0 next cycle, no stale result later, and a fresh transaction completes normally.
- Regression: W=32, STAGES=1, unsigned, 20000 entries from the shared A/B/P testvector files, out_ready=1 -> all match. Repeat with STAGES=4 and W=16 random, signed and unsigned, checked against a behavioural model.

Source files
------------

// File: rtl/bmult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: digit encoding,
// window recoding and partial-product count.
package bmult_pkg;

    typedef enum logic [2:0] {
        BD_ZERO,
        BD_P1,
        BD_P2,
        BD_M1,
        BD_M2
    } booth_digit_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_encode(input logic [2:0] win);
        booth_digit_t d;
        case (win)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_M2;
            3'b101, 3'b110: d = BD_M1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

    function automatic int n_pp(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/bmult_booth_pp.sv
// One Booth partial-product row: selects 0, +-A or +-2A, sign-extends to 2W,
// and shifts into place. Negation is one's complement plus a separate carry bit.
module bmult_booth_pp
    import bmult_pkg::*;
#(
    parameter int W     = 32,
    parameter int SHIFT = 0
) (
    input  booth_digit_t     digit,
    input  logic [W:0]       a_ext,
    output logic [2*W-1:0]   row,
    output logic             neg
);

    logic [W+1:0]   mag;
    logic [W+1:0]   inv;
    logic [2*W-1:0] ext;

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (digit)
            BD_P1: mag = {a_ext[W], a_ext};
            BD_P2: mag = {a_ext, 1'b0};
            BD_M1: begin
                mag = {a_ext[W], a_ext};
                neg = 1'b1;
            end
            BD_M2: begin
                mag = {a_ext, 1'b0};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        // Invert before shifting so the vacated low bits stay zero; the +1 lands at SHIFT.
        inv = neg ? ~mag : mag;
        ext = {{(W-2){inv[W+1]}}, inv};
        row = ext << SHIFT;
    end

endmodule

// File: rtl/bmult_pipe.sv
// Pipelined radix-4 Booth multiplier with signed/unsigned mode per transaction
// and a globally stalled valid/ready pipeline of STAGES register levels.
module bmult_pipe
    import bmult_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           is_signed,
    output logic [2*W-1:0] P,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int NPP  = n_pp(W);
    localparam int NR   = NPP + 1;
    localparam int HALF = NR / 2;

    typedef logic [2*W-1:0]          row_t;
    typedef logic [NR-1:0][2*W-1:0]  rows_t;

    // Handshake: in_valid/A/B/is_signed transfer when in_valid && in_ready;
    // P transfers when out_valid && out_ready. The whole pipe freezes on a stall.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en && !rst;

    logic [W:0]   a_ext;
    logic [W+2:0] b_ext;
    assign a_ext = {is_signed & A[W-1], A};
    assign b_ext = {{2{is_signed & B[W-1]}}, B, 1'b0};

    booth_digit_t      digit  [NPP];
    row_t              pp_row [NPP];
    logic [NPP-1:0]    pp_neg;

    generate
        for (genvar i = 0; i < NPP; i++) begin : g_pp
            assign digit[i] = booth_encode(b_ext[2*i+2 -: 3]);
            bmult_booth_pp #(
                .W     (W),
                .SHIFT (2*i)
            ) u_pp (
                .digit (digit[i]),
                .a_ext (a_ext),
                .row   (pp_row[i]),
                .neg   (pp_neg[i])
            );
        end
    endgenerate

    // Last row gathers every negate carry; their positions 2i never collide.
    rows_t rows_c;
    always_comb begin
        rows_c = '0;
        for (int i = 0; i < NPP; i++) begin
            rows_c[i]       = pp_row[i];
            rows_c[NPP][2*i] = pp_neg[i];
        end
    end

    // Linear carry-save chain over rows 0..n-1; returns {carry, sum}.
    function automatic logic [4*W-1:0] csa_chain(input rows_t x, input int n);
        row_t s;
        row_t c;
        row_t t;
        s = x[0];
        c = x[1];
        for (int i = 2; i < NR; i++) begin
            if (i < n) begin
                t = s ^ c ^ x[i];
                c = ((s & c) | (s & x[i]) | (c & x[i])) << 1;
                s = t;
            end
        end
        return {c, s};
    endfunction

    function automatic row_t cpa(input logic [4*W-1:0] cs);
        return cs[2*W-1:0] + cs[4*W-1:2*W];
    endfunction

    row_t p_next;

    generate
        if (STAGES == 1) begin : g_one
            assign p_next = cpa(csa_chain(rows_c, NR));
        end else begin : g_multi
            rows_t pp_q;
            always_ff @(posedge clk) begin
                if (en) pp_q <= rows_c;
            end

            if (STAGES == 2) begin : g_two
                assign p_next = cpa(csa_chain(pp_q, NR));
            end else if (STAGES == 3) begin : g_three
                logic [4*W-1:0] cs_q;
                always_ff @(posedge clk) begin
                    if (en) cs_q <= csa_chain(pp_q, NR);
                end
                assign p_next = cpa(cs_q);
            end else begin : g_four
                // First half of the rows compressed here, the rest forwarded untouched.
                rows_t          part_c;
                rows_t          part_q;
                logic [4*W-1:0] head;
                logic [4*W-1:0] cs_q;
                always_comb begin
                    head   = csa_chain(pp_q, HALF);
                    part_c = '0;
                    for (int i = HALF; i < NR; i++) part_c[i] = pp_q[i];
                    part_c[0] = head[2*W-1:0];
                    part_c[1] = head[4*W-1:2*W];
                end
                always_ff @(posedge clk) begin
                    if (en) begin
                        part_q <= part_c;
                        cs_q   <= csa_chain(part_q, NR);
                    end
                end
                assign p_next = cpa(cs_q);
            end
        end
    endgenerate

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_nxt;
    assign vld_nxt   = (vld << 1) | STAGES'(in_valid);
    assign out_valid = vld[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            P   <= '0;
        end else if (en) begin
            vld <= vld_nxt;
            if (vld_nxt[STAGES-1]) P <= p_next;
        end
    end

endmodule

// File: tb/tb_bmult_pipe.sv
// Self-checking bench for bmult_pipe: directed and random traffic on a 32x32/3-stage
// instance plus random regressions on 32x32/1-stage and 16x16/4-stage instances.
module tb_bmult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_r;

    logic        iv0, ir0, sg0, or0, ov0;
    logic [31:0] a0, b0;
    logic [63:0] p0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    bmult_pipe #(.W(32), .STAGES(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .A         (a0),
        .B         (b0),
        .is_signed (sg0),
        .P         (p0),
        .out_valid (ov0),
        .out_ready (or0)
    );

    // Reference product from plain integer arithmetic, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input int w, input logic sg);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic [63:0]        pr;
        if (sg) begin
            ea = $signed(a << (64 - w)) >>> (64 - w);
            eb = $signed(b << (64 - w)) >>> (64 - w);
        end else begin
            ea = $signed(a);
            eb = $signed(b);
        end
        pr = ea * eb;
        if (w < 32) pr = pr & ((64'd1 << (2 * w)) - 64'd1);
        return pr;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] e);
        bit ok;
        ok  = 1'b0;
        a0  = a;
        b0  = b;
        sg0 = sg;
        iv0 = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ir0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) exp_q.push_back(e);
        else fail_now("send_timeout");
        @(posedge clk);
        #1;
        iv0 = 1'b0;
    endtask

    task automatic drain0(input string name);
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ov0 && or0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got P=%h, required no output", p0);
            end else begin
                check("result", p0, exp_q.pop_front());
            end
        end
    end

    // Regression instances: {width, stages, signed allowed, random out_ready}.
    localparam int CW   [2] = '{32, 16};
    localparam int CS   [2] = '{1, 4};
    localparam int CSG  [2] = '{0, 1};
    localparam int CRND [2] = '{0, 1};
    localparam int NTX      = 400;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_reg
            localparam int RW = CW[g];
            localparam int RS = CS[g];

            logic            iv, ir, sg, ordy, ov, done;
            logic [RW-1:0]   a, b;
            logic [2*RW-1:0] p;
            logic [63:0]     q[$];

            bmult_pipe #(.W(RW), .STAGES(RS)) u_reg (
                .clk       (clk),
                .rst       (rst_r),
                .in_valid  (iv),
                .in_ready  (ir),
                .A         (a),
                .B         (b),
                .is_signed (sg),
                .P         (p),
                .out_valid (ov),
                .out_ready (ordy)
            );

            initial begin
                iv   = 1'b0;
                sg   = 1'b0;
                a    = '0;
                b    = '0;
                ordy = 1'b1;
                done = 1'b0;
                @(posedge clk);
                while (rst_r) @(posedge clk);
                #1;
                for (int n = 0; n < NTX; n++) begin
                    case ($urandom_range(0, 7))
                        0:       a = {1'b1, {(RW-1){1'b0}}};
                        1:       a = '1;
                        default: a = RW'($urandom);
                    endcase
                    case ($urandom_range(0, 7))
                        0:       b = {1'b1, {(RW-1){1'b0}}};
                        1:       b = '1;
                        default: b = RW'($urandom);
                    endcase
                    sg   = (CSG[g] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                    iv   = ($urandom_range(0, 4) != 0);
                    ordy = (CRND[g] != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
                    @(negedge clk);
                    if (iv && ir) q.push_back(ref_mul(64'(a), 64'(b), RW, sg));
                    @(posedge clk);
                    #1;
                end
                iv   = 1'b0;
                ordy = 1'b1;
                for (int t = 0; t < 40 && q.size() != 0; t++) @(negedge clk);
                if (q.size() != 0) fail_now($sformatf("reg%0d_drain", g));
                done = 1'b1;
            end

            always @(negedge clk) begin
                if (!rst_r && ov && ordy) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL reg%0d_unexpected: got P=%h, required no output", g, p);
                    end else begin
                        check($sformatf("reg%0d_result", g), 64'(p), q.pop_front());
                    end
                end
            end
        end
    endgenerate

    initial begin
        int          lat;
        logic [63:0] held;
        bit          stop;
        logic [31:0] ra, rb;
        logic        rs;

        rst   = 1'b1;
        rst_r = 1'b1;
        iv0   = 1'b0;
        a0    = '0;
        b0    = '0;
        sg0   = 1'b0;
        or0   = 1'b1;
        stop  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(ir0), 64'd0);
        check("rst_out_valid", 64'(ov0), 64'd0);
        check("rst_p", p0, 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rst_r = 1'b0;
        @(negedge clk);
        check("in_ready_after_release", 64'(ir0), 64'd1);
        @(posedge clk);
        #1;

        // Largest unsigned product and exact latency.
        send0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        lat = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (ov0) begin
                lat = t;
                break;
            end
        end
        check("latency", 64'(lat), 64'd3);
        drain0("drain_latency");

        send0(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        send0(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        drain0("drain_signed");

        for (int i = 0; i < 6; i++) begin
            send0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'(i % 2),
                  (i % 2 != 0) ? 64'h0000_0000_0000_0001 : 64'hFFFF_FFFE_0000_0001);
        end
        drain0("drain_alternate");

        // Eight back-to-back transactions with a four-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    send0(ra, rb, rs, ref_mul(64'(ra), 64'(rb), 32, rs));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                or0 = 1'b0;
                held = '0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("stall_out_valid", 64'(ov0), 64'd1);
                    check("stall_in_ready", 64'(ir0), 64'd0);
                    if (i == 0) held = p0;
                    else check("stall_p_stable", p0, held);
                end
                @(posedge clk);
                #1;
                or0 = 1'b1;
            end
        join
        drain0("drain_stall");

        // Random traffic with random gaps and random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    send0(ra, rb, rs, ref_mul(64'(ra), 64'(rb), 32, rs));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    or0 = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                or0 = 1'b1;
            end
        join
        drain0("drain_random");

        // Reset with three transactions in flight: all must vanish.
        for (int i = 0; i < 3; i++) begin
            send0(32'h0000_1000 + 32'(i), 32'h0000_0003, 1'b0,
                  ref_mul(64'(32'h0000_1000 + 32'(i)), 64'd3, 32, 1'b0));
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_out_valid", 64'(ov0), 64'd0);
        check("flush_p", p0, 64'd0);
        check("flush_in_ready", 64'(ir0), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_out_valid", 64'(ov0), 64'd0);
        end
        @(posedge clk);
        #1;
        send0(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        send0(32'h1234_5678, 32'h9ABC_DEF0, 1'b0,
              ref_mul(64'h1234_5678, 64'h9ABC_DEF0, 32, 1'b0));
        drain0("drain_after_reset");

        for (int t = 0; t < 20000 && !(g_reg[0].done && g_reg[1].done); t++) @(posedge clk);
        if (!(g_reg[0].done && g_reg[1].done)) fail_now("regression_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
